// File: rtl/res_uart_tx_pkg.sv
// Shared constants and FSM encoding for the response-path UART transmitter.
package res_uart_tx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_POP  = 2'd1;
  localparam state_t ST_CAPT = 2'd2;
  localparam state_t ST_SEND = 2'd3;

  localparam int   FRAME_BITS = 10;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam logic IDLE_LVL   = 1'b1;

endpackage

// File: rtl/uart_tx_core.sv
// Byte-level 8N1 serialiser; done_o marks the final stop-bit cycle so a new
// start_i on that cycle yields back-to-back frames.
module uart_tx_core
  import res_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);

  logic          active_q, active_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  assign done_o = active_q && (bit_q == LAST_BIT) && (cnt_q == '0);
  assign tx_o   = tx_q;

  // Bit timer counts down; each terminal count advances to the next frame bit.
  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    if (start_i) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      cnt_d    = CNT_TC;
      sh_d     = byte_i;
      tx_d     = START_LVL;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (bit_q == LAST_BIT) begin
        active_d = 1'b0;
        bit_d    = 4'd0;
        tx_d     = IDLE_LVL;
      end else begin
        bit_d = bit_q + 4'd1;
        cnt_d = CNT_TC;
        if (bit_q == 4'd8) begin
          tx_d = STOP_LVL;
        end else begin
          tx_d = sh_q[0];
          sh_d = {1'b0, sh_q[7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      sh_q     <= 8'd0;
      tx_q     <= IDLE_LVL;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/res_uart_tx.sv
// Pops response words from the FIFO and sends them MSB byte first as 8N1 frames.
// Define RES_UART_TX_CHECKSUM_EN to append an XOR-of-bytes frame to every word.
module res_uart_tx
  import res_uart_tx_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             rclk,
  input  logic             r_reset,
  input  logic             eflag,
  input  logic [WIDTH-1:0] rdata,
  output logic             ren,
  output logic             tx,
  output logic             busy
);

  localparam int BYTES = WIDTH / 8;
  localparam int IW    = $clog2(BYTES + 1);
`ifdef RES_UART_TX_CHECKSUM_EN
  localparam int LAST  = BYTES;
`else
  localparam int LAST  = BYTES - 1;
`endif

  state_t           state_q, state_d;
  logic             ren_q, ren_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    nidx;
  logic [WIDTH-1:0] word_shift;
  logic             start;
  logic [7:0]       byte_sel;
  logic             done;
`ifdef RES_UART_TX_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  assign ren  = ren_q;
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    ren_d      = 1'b0;
    word_d     = word_q;
    idx_d      = idx_q;
    start      = 1'b0;
    nidx       = idx_q + 1'b1;
    word_shift = word_q << {nidx, 3'b000};
    byte_sel   = rdata[WIDTH-1 -: 8];
`ifdef RES_UART_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!eflag) begin
          state_d = ST_POP;
          ren_d   = 1'b1;
        end
      end
      ST_POP: state_d = ST_CAPT;
      ST_CAPT: begin
        // First byte goes straight from rdata so its start bit follows capture.
        word_d   = rdata;
        idx_d    = '0;
        start    = 1'b1;
        byte_sel = rdata[WIDTH-1 -: 8];
`ifdef RES_UART_TX_CHECKSUM_EN
        csum_d   = rdata[WIDTH-1 -: 8];
`endif
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (done) begin
          if (idx_q == IW'(LAST)) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d    = nidx;
            start    = 1'b1;
            byte_sel = word_shift[WIDTH-1 -: 8];
`ifdef RES_UART_TX_CHECKSUM_EN
            if (nidx == IW'(BYTES)) byte_sel = csum_q;
            else                    csum_d   = csum_q ^ word_shift[WIDTH-1 -: 8];
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge r_reset) begin
    if (r_reset) begin
      state_q <= ST_IDLE;
      ren_q   <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef RES_UART_TX_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
`ifdef RES_UART_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk_i  (rclk),
    .rst_i  (r_reset),
    .start_i(start),
    .byte_i (byte_sel),
    .tx_o   (tx),
    .done_o (done)
  );

endmodule

// File: tb/tb_res_uart_tx.sv
// Directed bench for res_uart_tx with CLKS_PER_BIT=4 and a queue-backed FIFO model.
module tb_res_uart_tx;

  localparam int WIDTH = 32;
  localparam int CPB   = 4;
`ifdef RES_UART_TX_CHECKSUM_EN
  localparam int NFR = 5;
`else
  localparam int NFR = 4;
`endif
  localparam int FRAME_CYC = 10 * CPB;
  localparam int LAT       = 2 + NFR * FRAME_CYC;
  localparam int LOGN      = 8192;

  logic             rclk    = 1'b0;
  logic             r_reset = 1'b1;
  logic             eflag   = 1'b1;
  logic [WIDTH-1:0] rdata   = '0;
  logic             ren, tx, busy;

  res_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .rclk   (rclk),
    .r_reset(r_reset),
    .eflag  (eflag),
    .rdata  (rdata),
    .ren    (ren),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [31:0] word;
    logic [39:0] bytes;   // expected frames in order, incl. XOR byte last
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic tx_log [0:LOGN-1];
  int   ren_cnt = 0;
  int   ren_cyc [0:63];
  int   fall_cnt = 0;
  int   fall_cyc [0:63];
  logic busy_prev = 1'b0;
  int   txlow_cnt = 0;
  int   ef_mode = 2;   // 0: FIFO model, 1: force non-empty, 2: force empty
  logic [WIDTH-1:0] q[$];

  always @(negedge rclk) begin
    cyc = cyc + 1;
    if (cyc < LOGN) tx_log[cyc] = tx;
    if (tx !== 1'b1) txlow_cnt++;
    if (ren === 1'b1) begin
      if (ren_cnt < 64) ren_cyc[ren_cnt] = cyc;
      ren_cnt++;
    end
    if (busy_prev === 1'b1 && busy === 1'b0) begin
      if (fall_cnt < 64) fall_cyc[fall_cnt] = cyc;
      fall_cnt++;
    end
    busy_prev = busy;
  end

  always @(negedge rclk) begin
    if (ren === 1'b1 && q.size() > 0) rdata = q.pop_front();
    case (ef_mode)
      1:       eflag = 1'b0;
      2:       eflag = 1'b1;
      default: eflag = (q.size() == 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge rclk);
    #1;
  endtask

  task automatic wait_falls(input int target, input string name);
    int b = 0;
    while (fall_cnt < target && b < 3000) begin
      @(negedge rclk); #1; b++;
    end
    if (fall_cnt < target) chk({name, "_busy_timeout"}, fall_cnt, target);
  endtask

  task automatic wait_ren(input int target, input string name);
    int b = 0;
    while (ren_cnt < target && b < 3000) begin
      @(negedge rclk); #1; b++;
    end
    if (ren_cnt < target) chk({name, "_ren_timeout"}, ren_cnt, target);
  endtask

  task automatic check_frame(input string name, input int s, input logic [7:0] b);
    logic [9:0] exp;
    logic [9:0] got;
    int idx;
    exp = {1'b1, b, 1'b0};
    got = exp;
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < CPB; k++) begin
        idx = s + j * CPB + k;
        if (idx >= LOGN || tx_log[idx] !== exp[j]) got[j] = ~exp[j];
      end
    chk(name, {22'd0, got}, {22'd0, exp});
  endtask

  task automatic check_word(input string name, input int r, input logic [39:0] bytes);
    logic [39:0] bv;
    bv = bytes;
    for (int k = 0; k < NFR; k++)
      check_frame($sformatf("%s_frame%0d", name, k), r + 2 + k * FRAME_CYC, bv[39 - 8*k -: 8]);
  endtask

  vec_t tbl [6];

  initial begin
    int rbase, fbase, lbase, r, target, b;

    tbl[0] = '{word: 32'hA5C30F81, bytes: 40'hA5C30F81E8};
    tbl[1] = '{word: 32'h00000000, bytes: 40'h0000000000};
    tbl[2] = '{word: 32'hFFFFFFFF, bytes: 40'hFFFFFFFF00};
    tbl[3] = '{word: 32'h12345678, bytes: 40'h1234567808};
    tbl[4] = '{word: 32'h80000001, bytes: 40'h8000000181};
    tbl[5] = '{word: 32'h01020304, bytes: 40'h0102030404};

    // Reset held with eflag low
    ef_mode = 1;
    wait_cycles(5);
    chk("rst_tx", tx, 1);
    chk("rst_ren", ren, 0);
    chk("rst_busy", busy, 0);

    ef_mode = 2;
    wait_cycles(1);
    r_reset = 1'b0;
    rbase = ren_cnt; lbase = txlow_cnt;
    wait_cycles(1000);
    chk("idle_no_ren", ren_cnt - rbase, 0);
    chk("idle_tx_high", txlow_cnt - lbase, 0);

    ef_mode = 0;
    foreach (tbl[i]) begin
      rbase = ren_cnt; fbase = fall_cnt;
      q.push_back(tbl[i].word);
      wait_falls(fbase + 1, $sformatf("vec%0d", i));
      wait_cycles(5);
      chk($sformatf("vec%0d_ren_count", i), ren_cnt - rbase, 1);
      if (ren_cnt > rbase && fall_cnt > fbase) begin
        r = ren_cyc[rbase];
        chk($sformatf("vec%0d_latency", i), fall_cyc[fbase] - r, LAT);
        check_word($sformatf("vec%0d", i), r, tbl[i].bytes);
      end
    end

    // Two queued words
    rbase = ren_cnt; fbase = fall_cnt;
    q.push_back(32'hA5C30F81);
    q.push_back(32'h12345678);
    wait_falls(fbase + 2, "two");
    wait_cycles(5);
    chk("two_ren_count", ren_cnt - rbase, 2);
    if (ren_cnt >= rbase + 2 && fall_cnt >= fbase + 2) begin
      chk("two_second_ren", ren_cyc[rbase + 1] - fall_cyc[fbase], 1);
      check_word("two_w0", ren_cyc[rbase], tbl[0].bytes);
      check_word("two_w1", ren_cyc[rbase + 1], tbl[3].bytes);
    end

    // eflag rises during CAPT
    rbase = ren_cnt; fbase = fall_cnt;
    q.push_back(32'h12345678);
    q.push_back(32'hA5C30F81);
    wait_ren(rbase + 1, "capt");
    @(posedge rclk); #1;
    ef_mode = 2;
    wait_falls(fbase + 1, "capt");
    wait_cycles(200);
    chk("capt_ren_count", ren_cnt - rbase, 1);
    if (ren_cnt > rbase) check_word("capt_w0", ren_cyc[rbase], tbl[3].bytes);
    q.delete();
    ef_mode = 0;

    // Reset during data bit 3 of byte 2
    rbase = ren_cnt;
    q.push_back(32'h00000000);
    wait_ren(rbase + 1, "mid");
    r = ren_cyc[rbase];
    target = r + 2 + 2 * FRAME_CYC + 4 * CPB;
    b = 0;
    while (cyc < target && b < 2000) begin
      @(negedge rclk); #1; b++;
    end
    chk("mid_tx_before_reset", tx, 0);
    ef_mode = 2;
    r_reset = 1'b1;
    #1;
    chk("mid_reset_tx", tx, 1);
    chk("mid_reset_busy", busy, 0);
    wait_cycles(3);
    r_reset = 1'b0;
    rbase = ren_cnt; lbase = txlow_cnt;
    wait_cycles(1000);
    chk("post_reset_no_ren", ren_cnt - rbase, 0);
    chk("post_reset_tx_high", txlow_cnt - lbase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
